// File: rtl/cbb_async_event_sync_if.sv
// Signal bundle for cbb_async_event_sync: asynchronous event inputs, per-channel
// controls and the synchronised per-channel status outputs.
interface cbb_async_event_sync_if #(
    parameter int P_CH_NUM = 4
);
    logic [P_CH_NUM-1:0] i_async;
    logic [P_CH_NUM-1:0] i_ch_en;
    logic [P_CH_NUM-1:0] i_ovf_clr;
    logic [P_CH_NUM-1:0] o_pulse;
    logic [P_CH_NUM-1:0] o_level;
    logic [P_CH_NUM-1:0] o_pending;
    logic [P_CH_NUM-1:0] o_ovf;

    modport master (output i_async, i_ch_en, i_ovf_clr,
                    input  o_pulse, o_level, o_pending, o_ovf);
    modport slave  (input  i_async, i_ch_en, i_ovf_clr,
                    output o_pulse, o_level, o_pending, o_ovf);
endinterface

// File: rtl/cbb_async_event_sync.sv
// Multi-channel async event synchroniser: sync chain, deglitch filter, edge
// detect, then a pulse/gap FSM with a one-deep pending slot and sticky overflow.
module cbb_async_event_sync_ch #(
    parameter int P_SYNC_STAGE  = 2,
    parameter int P_FILTER_LEN  = 1,
    parameter     P_EDGE_MODE   = "RISE",
    parameter int P_PULSE_WIDTH = 1,
    parameter int P_MIN_GAP     = 0
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_async,
    input  logic i_en,
    input  logic i_ovf_clr,
    output logic o_pulse,
    output logic o_level,
    output logic o_pending,
    output logic o_ovf
);
    localparam int CNT_W  = (P_FILTER_LEN > 1) ? $clog2(P_FILTER_LEN) : 1;
    localparam int PMAX   = (P_PULSE_WIDTH > P_MIN_GAP) ? P_PULSE_WIDTH : P_MIN_GAP;
    localparam int PCNT_W = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam bit EM_RISE = (P_EDGE_MODE == "RISE") || (P_EDGE_MODE == "BOTH");
    localparam bit EM_FALL = (P_EDGE_MODE == "FALL") || (P_EDGE_MODE == "BOTH");
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(P_FILTER_LEN - 1);
    localparam logic [PCNT_W-1:0] PW_LAST  = PCNT_W'(P_PULSE_WIDTH - 1);
    localparam logic [PCNT_W-1:0] GAP_LAST = PCNT_W'((P_MIN_GAP > 0) ? P_MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_e;

    logic [P_SYNC_STAGE-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
    logic                    level_q, level_d;
    logic                    evt_q, evt_d;
    logic                    pend_q, pend_d;
    logic                    ovf_q, ovf_d;
    state_e                  state_q, state_d;
    logic                    synced, ev, dispatch, ovf_set;

    assign synced = sync_q[P_SYNC_STAGE-1];
    assign ev     = evt_q & i_en;

    always_comb begin
        sync_d  = {sync_q[P_SYNC_STAGE-2:0], i_async};
        level_d = level_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = synced;
            cnt_d   = '0;
            evt_d   = synced ? EM_RISE : EM_FALL;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        pend_d   = pend_q;
        ovf_set  = 1'b0;
        dispatch = 1'b0;
        case (state_q)
            ST_IDLE: if (ev) begin
                state_d = ST_PULSE;
                pcnt_d  = '0;
            end
            ST_PULSE: if (pcnt_q == PW_LAST) begin
                if (P_MIN_GAP > 0) begin
                    state_d = ST_GAP;
                    pcnt_d  = '0;
                end else begin
                    dispatch = 1'b1;
                end
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
            ST_GAP: if (pcnt_q == GAP_LAST) dispatch = 1'b1;
                    else pcnt_d = pcnt_q + 1'b1;
            default: state_d = ST_IDLE;
        endcase
        // A same-cycle event on dispatch is launched directly if nothing is
        // queued; if something is queued it takes the freed pending slot.
        if (dispatch) begin
            if (pend_q || ev) begin
                state_d = ST_PULSE;
                pcnt_d  = '0;
                pend_d  = pend_q & ev;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q != ST_IDLE) && ev) begin
            if (pend_q) ovf_set = 1'b1;
            else        pend_d  = 1'b1;
        end
        if (!i_en) pend_d = 1'b0;
        ovf_d = (ovf_q & ~i_ovf_clr) | ovf_set;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            evt_q   <= evt_d;
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_pulse   = (state_q == ST_PULSE);
    assign o_level   = level_q;
    assign o_pending = pend_q;
    assign o_ovf     = ovf_q;
endmodule

module cbb_async_event_sync #(
    parameter int P_CH_NUM      = 4,
    parameter int P_SYNC_STAGE  = 2,
    parameter int P_FILTER_LEN  = 1,
    parameter     P_EDGE_MODE   = "RISE",
    parameter int P_PULSE_WIDTH = 1,
    parameter int P_MIN_GAP     = 0
) (
    input logic                  i_clk,
    input logic                  i_rstn,
    cbb_async_event_sync_if.slave bus
);
    logic [P_CH_NUM-1:0] pulse_w, level_w, pend_w, ovf_w;

    for (genvar g = 0; g < P_CH_NUM; g++) begin : g_ch
        cbb_async_event_sync_ch #(
            .P_SYNC_STAGE (P_SYNC_STAGE),
            .P_FILTER_LEN (P_FILTER_LEN),
            .P_EDGE_MODE  (P_EDGE_MODE),
            .P_PULSE_WIDTH(P_PULSE_WIDTH),
            .P_MIN_GAP    (P_MIN_GAP)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rstn   (i_rstn),
            .i_async  (bus.i_async[g]),
            .i_en     (bus.i_ch_en[g]),
            .i_ovf_clr(bus.i_ovf_clr[g]),
            .o_pulse  (pulse_w[g]),
            .o_level  (level_w[g]),
            .o_pending(pend_w[g]),
            .o_ovf    (ovf_w[g])
        );
    end

    assign bus.o_pulse   = pulse_w;
    assign bus.o_level   = level_w;
    assign bus.o_pending = pend_w;
    assign bus.o_ovf     = ovf_w;
endmodule

// File: tb/tb_cbb_async_event_sync.sv
// Directed bench for cbb_async_event_sync: five instances cover the default,
// long-filter, pulse/gap queueing, both-edge and falling-edge configurations.
module tb_cbb_async_event_sync;
    logic clk = 1'b0;
    logic rstn;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    cbb_async_event_sync_if #(.P_CH_NUM(4)) a ();
    cbb_async_event_sync_if #(.P_CH_NUM(1)) b ();
    cbb_async_event_sync_if #(.P_CH_NUM(2)) c ();
    cbb_async_event_sync_if #(.P_CH_NUM(1)) d ();
    cbb_async_event_sync_if #(.P_CH_NUM(1)) e ();

    cbb_async_event_sync #(.P_CH_NUM(4)) u_a (.i_clk(clk), .i_rstn(rstn), .bus(a));
    cbb_async_event_sync #(.P_CH_NUM(1), .P_FILTER_LEN(3)) u_b (.i_clk(clk), .i_rstn(rstn), .bus(b));
    cbb_async_event_sync #(.P_CH_NUM(2), .P_PULSE_WIDTH(3), .P_MIN_GAP(2)) u_c (.i_clk(clk), .i_rstn(rstn), .bus(c));
    cbb_async_event_sync #(.P_CH_NUM(1), .P_EDGE_MODE("BOTH")) u_d (.i_clk(clk), .i_rstn(rstn), .bus(d));
    cbb_async_event_sync #(.P_CH_NUM(1), .P_EDGE_MODE("FALL")) u_e (.i_clk(clk), .i_rstn(rstn), .bus(e));

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        a.i_async = '0; a.i_ch_en = '1; a.i_ovf_clr = '0;
        b.i_async = '0; b.i_ch_en = '1; b.i_ovf_clr = '0;
        c.i_async = '0; c.i_ch_en = '1; c.i_ovf_clr = '0;
        d.i_async = '0; d.i_ch_en = '1; d.i_ovf_clr = '0;
        e.i_async = '0; e.i_ch_en = '1; e.i_ovf_clr = '0;
        #1;
        n_chk++; if ({a.o_pulse, a.o_level, a.o_pending, a.o_ovf} !== 16'h0) $display("FAIL rst_a got %h exp 0", {a.o_pulse, a.o_level, a.o_pending, a.o_ovf}); else n_pass++;
        n_chk++; if ({c.o_pulse, c.o_level, c.o_pending, c.o_ovf} !== 8'h0) $display("FAIL rst_c got %h exp 0", {c.o_pulse, c.o_level, c.o_pending, c.o_ovf}); else n_pass++;
        tick(2);
        rstn = 1'b1;
        tick(3);
        n_chk++; if ({a.o_pulse, a.o_level, b.o_pulse, d.o_pulse, e.o_pulse} !== 11'h0) $display("FAIL rst_idle got %h exp 0", {a.o_pulse, a.o_level, b.o_pulse, d.o_pulse, e.o_pulse}); else n_pass++;
    endtask

    task automatic test_latency();
        a.i_async = 4'b0001;
        tick(2);
        n_chk++; if (a.o_level !== 4'b0000) $display("FAIL lat_level_e2 got %b exp 0000", a.o_level); else n_pass++;
        tick();
        n_chk++; if (a.o_level !== 4'b0001) $display("FAIL lat_level_e3 got %b exp 0001", a.o_level); else n_pass++;
        n_chk++; if (a.o_pulse !== 4'b0000) $display("FAIL lat_pulse_e3 got %b exp 0000", a.o_pulse); else n_pass++;
        tick();
        n_chk++; if (a.o_pulse !== 4'b0001) $display("FAIL lat_pulse_e4 got %b exp 0001", a.o_pulse); else n_pass++;
        tick();
        n_chk++; if (a.o_pulse !== 4'b0000) $display("FAIL lat_pulse_e5 got %b exp 0000", a.o_pulse); else n_pass++;
        a.i_async = '0;
        tick(5);
    endtask

    task automatic test_filter();
        logic seen_lvl, seen_pls;
        seen_lvl = 1'b0; seen_pls = 1'b0;
        b.i_async = 1'b1;
        tick(2);
        b.i_async = 1'b0;
        repeat (8) begin
            tick();
            seen_lvl |= b.o_level[0];
            seen_pls |= b.o_pulse[0];
        end
        n_chk++; if (seen_lvl !== 1'b0) $display("FAIL glitch_level got %b exp 0", seen_lvl); else n_pass++;
        n_chk++; if (seen_pls !== 1'b0) $display("FAIL glitch_pulse got %b exp 0", seen_pls); else n_pass++;
        b.i_async = 1'b1;
        tick(4);
        n_chk++; if (b.o_level !== 1'b0) $display("FAIL filt_level_e4 got %b exp 0", b.o_level); else n_pass++;
        tick();
        n_chk++; if (b.o_level !== 1'b1) $display("FAIL filt_level_e5 got %b exp 1", b.o_level); else n_pass++;
        n_chk++; if (b.o_pulse !== 1'b0) $display("FAIL filt_pulse_e5 got %b exp 0", b.o_pulse); else n_pass++;
        b.i_async = 1'b0;
        tick();
        n_chk++; if (b.o_pulse !== 1'b1) $display("FAIL filt_pulse_e6 got %b exp 1", b.o_pulse); else n_pass++;
        tick();
        n_chk++; if (b.o_pulse !== 1'b0) $display("FAIL filt_pulse_e7 got %b exp 0", b.o_pulse); else n_pass++;
        tick(8);
    endtask

    task automatic test_queue_ovf();
        logic [13:0] pls, pnd, ovf;
        pls = '0; pnd = '0; ovf = '0;
        for (int k = 1; k <= 14; k++) begin
            c.i_async[0] = (k <= 5) && (k % 2 == 1);
            tick();
            pls = {pls[12:0], c.o_pulse[0]};
            pnd = {pnd[12:0], c.o_pending[0]};
            ovf = {ovf[12:0], c.o_ovf[0]};
        end
        n_chk++; if (pls !== 14'b00011100111000) $display("FAIL q_pulse_seq got %b exp %b", pls, 14'b00011100111000); else n_pass++;
        n_chk++; if (pnd !== 14'b00000111000000) $display("FAIL q_pend_seq got %b exp %b", pnd, 14'b00000111000000); else n_pass++;
        n_chk++; if (ovf !== 14'b00000001111111) $display("FAIL q_ovf_seq got %b exp %b", ovf, 14'b00000001111111); else n_pass++;
        c.i_ovf_clr[0] = 1'b1;
        tick();
        c.i_ovf_clr[0] = 1'b0;
        n_chk++; if (c.o_ovf[0] !== 1'b0) $display("FAIL ovf_clear got %b exp 0", c.o_ovf[0]); else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            c.i_async[0] = (k <= 5) && (k % 2 == 1);
            if (k == 8) c.i_ovf_clr[0] = 1'b1;
            tick();
            if (k == 7) begin
                n_chk++; if (c.o_ovf[0] !== 1'b0) $display("FAIL ovf_pre_set got %b exp 0", c.o_ovf[0]); else n_pass++;
            end
        end
        c.i_ovf_clr[0] = 1'b0;
        n_chk++; if (c.o_ovf[0] !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", c.o_ovf[0]); else n_pass++;
        tick(8);
        c.i_ovf_clr[0] = 1'b1;
        tick();
        c.i_ovf_clr[0] = 1'b0;
        tick(2);
    endtask

    task automatic test_edge_modes();
        logic [19:0] sd, se;
        sd = '0; se = '0;
        for (int k = 1; k <= 20; k++) begin
            d.i_async = (k <= 10);
            e.i_async = (k <= 10);
            tick();
            sd = {sd[18:0], d.o_pulse[0]};
            se = {se[18:0], e.o_pulse[0]};
        end
        n_chk++; if (sd !== 20'h10040) $display("FAIL both_seq got %h exp %h", sd, 20'h10040); else n_pass++;
        n_chk++; if (se !== 20'h00040) $display("FAIL fall_seq got %h exp %h", se, 20'h00040); else n_pass++;
    endtask

    task automatic test_enable();
        logic seen;
        seen = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            c.i_async[1] = (k == 1) || (k == 3);
            tick();
        end
        n_chk++; if (c.o_pending[1] !== 1'b1) $display("FAIL en_pend_set got %b exp 1", c.o_pending[1]); else n_pass++;
        n_chk++; if (c.o_pulse[1] !== 1'b1) $display("FAIL en_pulse_busy got %b exp 1", c.o_pulse[1]); else n_pass++;
        c.i_ch_en[1] = 1'b0;
        tick();
        n_chk++; if (c.o_pending[1] !== 1'b0) $display("FAIL en_pend_clr got %b exp 0", c.o_pending[1]); else n_pass++;
        n_chk++; if (c.o_pulse[1] !== 1'b0) $display("FAIL en_pulse_done got %b exp 0", c.o_pulse[1]); else n_pass++;
        repeat (10) begin
            tick();
            seen |= c.o_pulse[1];
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL en_no_pulse got %b exp 0", seen); else n_pass++;
        n_chk++; if (c.o_ovf !== 2'b00) $display("FAIL en_ovf got %b exp 00", c.o_ovf); else n_pass++;
        c.i_ch_en[1] = 1'b1;
        c.i_async[1] = 1'b1;
        tick(3);
        n_chk++; if (c.o_pulse !== 2'b00) $display("FAIL reen_pulse_e3 got %b exp 00", c.o_pulse); else n_pass++;
        tick();
        n_chk++; if (c.o_pulse !== 2'b10) $display("FAIL reen_pulse_e4 got %b exp 10", c.o_pulse); else n_pass++;
        c.i_async[1] = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid_pulse();
        for (int k = 1; k <= 6; k++) begin
            c.i_async[0] = (k == 1) || (k == 3);
            tick();
        end
        n_chk++; if ({c.o_pulse[0], c.o_pending[0]} !== 2'b11) $display("FAIL mid_busy got %b exp 11", {c.o_pulse[0], c.o_pending[0]}); else n_pass++;
        #3;
        rstn = 1'b0;
        a.i_async = 4'b0100;
        #1;
        n_chk++; if ({c.o_pulse, c.o_pending, c.o_ovf, c.o_level} !== 8'h0) $display("FAIL mid_rst_async got %h exp 0", {c.o_pulse, c.o_pending, c.o_ovf, c.o_level}); else n_pass++;
        tick();
        rstn = 1'b1;
        tick(3);
        n_chk++; if (a.o_level !== 4'b0100) $display("FAIL rel_level_e3 got %b exp 0100", a.o_level); else n_pass++;
        n_chk++; if (a.o_pulse !== 4'b0000) $display("FAIL rel_pulse_e3 got %b exp 0000", a.o_pulse); else n_pass++;
        tick();
        n_chk++; if (a.o_pulse !== 4'b0100) $display("FAIL rel_pulse_e4 got %b exp 0100", a.o_pulse); else n_pass++;
        tick();
        n_chk++; if (a.o_pulse !== 4'b0000) $display("FAIL rel_pulse_e5 got %b exp 0000", a.o_pulse); else n_pass++;
        a.i_async = '0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_filter();
        test_queue_ovf();
        test_edge_modes();
        test_enable();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cbb_async_event_sync.md
Name: cbb_async_event_sync

Overview:
Multi-channel synchroniser for asynchronous event inputs such as external strobes, interrupts and buttons into a single clock domain. Each channel runs through a P_SYNC_STAGE flop chain, a stability (deglitch) filter and a selectable edge detector. Each detected event produces an output pulse of programmable width with a guaranteed minimum gap between pulses. Events that arrive while a channel is busy are held as one pending event; any further event while one is already pending sets a sticky overflow flag.

Parameters:
P_CH_NUM, 4, number of independent channels (>=1)
P_SYNC_STAGE, 2, synchroniser flop stages per channel (>=2)
P_FILTER_LEN, 1, consecutive cycles a synced level must differ from the filtered level before it is accepted (>=1)
P_EDGE_MODE, "RISE", "RISE" / "FALL" / "BOTH": which filtered-level transitions count as events
P_PULSE_WIDTH, 1, output pulse width in i_clk cycles (>=1)
P_MIN_GAP, 0, forced low cycles after each output pulse (>=0)

Ports:
i_clk  in  1  single clock; all logic on its rising edge
i_rstn  in  1  asynchronous active-low reset
i_async  in  P_CH_NUM  asynchronous event inputs, one bit per channel
i_ch_en  in  P_CH_NUM  per-channel enable, synchronous to i_clk
i_ovf_clr  in  P_CH_NUM  per-channel overflow clear strobe, synchronous to i_clk
o_pulse  out  P_CH_NUM  synchronised event pulses
o_level  out  P_CH_NUM  filtered, synchronised input level
o_pending  out  P_CH_NUM  a queued event is waiting
o_ovf  out  P_CH_NUM  sticky overflow (an event was lost)

Behaviour:
- Reset (asynchronous, i_rstn=0): all sync flops, filter counters, o_level, o_pulse, o_pending and o_ovf go to 0; every FSM goes to IDLE. Reset asserted mid-pulse drops o_pulse immediately. Because the chain starts at 0, an input that is high when reset releases is seen as a rising transition.
- Sync chain: s[0] <= i_async; s[k] <= s[k-1]; synced level = s[P_SYNC_STAGE-1].
- Filter, per channel:
  - If synced == o_level, cnt <= 0.
  - Else if cnt == P_FILTER_LEN-1: o_level <= synced, cnt <= 0, and raise the internal one-cycle strobe evt if the transition matches P_EDGE_MODE.
  - Else cnt <= cnt+1.
  - cnt width is clog2(P_FILTER_LEN), minimum 1.
  - Glitches shorter than P_FILTER_LEN cycles, measured at the sync output, are rejected.
- evt is qualified by i_ch_en. When i_ch_en=0, evt is discarded and pending is cleared on the next edge. A pulse already in progress completes. o_level keeps tracking the input.
- Per-channel FSM with states IDLE, PULSE, GAP and counter pcnt:
  - IDLE: on evt -> PULSE, pcnt <= 0.
  - PULSE: o_pulse=1 (registered). When pcnt == P_PULSE_WIDTH-1, go to GAP if P_MIN_GAP>0, otherwise go to the dispatch step; else pcnt++.
  - GAP: o_pulse=0. When pcnt == P_MIN_GAP-1, go to the dispatch step; else pcnt++.
  - Dispatch step: if pending=1 (or evt arrives this same cycle), go to PULSE, pcnt <= 0, and clear pending unless it is the same-cycle evt that is consumed. Otherwise go to IDLE.
  - Back-to-back pulses are therefore separated by exactly P_MIN_GAP low cycles. With P_MIN_GAP=0, o_pulse stays high continuously across merged pulses.
- Queueing:
  - evt in PULSE or GAP with pending=0 sets pending.
  - evt with pending=1 sets o_ovf, and the event is dropped.
  - evt exactly on the dispatch cycle is consumed directly, with no pending set.
- o_ovf is sticky. It is cleared by i_ovf_clr on the next edge. If a set and a clear occur in the same cycle, the set wins.
- Latency: count the first i_clk edge that samples the new input level as edge 1. The filtered level and evt update at edge P_SYNC_STAGE+P_FILTER_LEN. o_pulse rises at edge P_SYNC_STAGE+P_FILTER_LEN+1 when the FSM is IDLE. Default values give edge 4.
- Channels are fully independent; there is no arbitration between them.

Test Plan:
1. Defaults (P_CH_NUM=4, P_SYNC_STAGE=2, P_FILTER_LEN=1, P_EDGE_MODE="RISE", P_PULSE_WIDTH=1, P_MIN_GAP=0). Raise i_async[0] before edge 1 and hold it -> o_level[0]=1 at edge 3; o_pulse[0]=1 for exactly the cycle after edge 4; other channels stay 0.
2. P_FILTER_LEN=3. Apply a 2-cycle-wide high glitch -> no o_level change and no o_pulse. Then hold high for 5 cycles -> one pulse, rising at edge 2+3+1=6.
3. P_PULSE_WIDTH=3, P_MIN_GAP=2.
   - Feed three rising edges spaced 2 cycles apart -> first pulse 3 cycles high, 2 low, then a second 3-cycle pulse from pending; third event sets o_ovf=1.
   - Pulse i_ovf_clr -> o_ovf=0 next edge.
   - Assert i_ovf_clr on the same cycle as a new overflow -> o_ovf stays 1.
4. P_EDGE_MODE="BOTH". Drive a 10-cycle-high input -> two 1-cycle pulses, 10 cycles apart. P_EDGE_MODE="FALL" on the same stimulus -> only the second pulse.
5. Drop i_ch_en[1] while an event is pending on channel 1 -> the current pulse completes, o_pending[1] clears, and no further pulse occurs. Re-enable and send a new edge -> normal pulse.
6. Assert i_rstn=0 mid-pulse with pending set -> all outputs 0 asynchronously. Release reset with i_async[2]=1 held -> one pulse on channel 2 at edge 4 after release.
